// File: rtl/fdct_pkg.sv
// Shared definitions for the fdct datapath: cosine magnitude table, FSM states,
// point count and width helpers used by the DCT engine and its coefficient ROM.
// No ports; imported with `import fdct_pkg::*`.
package fdct_pkg;

  localparam int N_POINTS = 8;
  localparam int CNT_W    = $clog2(N_POINTS);

  // Cosine angles are indexed in units of pi/16, so the phase wraps mod 32.
  localparam int PHASE_W  = 5;

  // Quarter-wave cosine magnitudes, scale 32 = 1.0, for angles 0..8 (x pi/16).
  localparam int TAB_W    = 6;
  localparam logic [TAB_W-1:0] TAB [0:8] = '{
    6'd32, 6'd31, 6'd30, 6'd27, 6'd23, 6'd18, 6'd12, 6'd6, 6'd0
  };

  // DC row uses 32/sqrt(2) rounded, folding the orthonormal DC scale in.
  localparam logic [TAB_W-1:0] C0_MAG = 6'd23;

  typedef enum logic [1:0] {
    LOAD,
    MAC,
    OUT
  } state_e;

  function automatic int prod_width(input int data_w, input int coef_w);
    return data_w + coef_w;
  endfunction

  // Eight products of full width need 3 guard bits to never wrap.
  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 3;
  endfunction

endpackage

// File: rtl/dct8_coef_rom.sv
// Combinational cosine coefficient lookup C[k][n] for the 8-point DCT.
// Latency: combinational. Backpressure: none (pure function of k_i, n_i).
// Ports: k_i/n_i coefficient row/column, coef_o signed coefficient (32 = 1.0).
module dct8_coef_rom
  import fdct_pkg::*;
#(
  parameter int COEF_W = 8
) (
  input  logic [CNT_W-1:0]         k_i,
  input  logic [CNT_W-1:0]         n_i,
  output logic signed [COEF_W-1:0] coef_o
);

  logic [PHASE_W-1:0]       m;
  logic [3:0]               idx;
  logic                     neg;
  logic [TAB_W-1:0]         mag;
  logic signed [COEF_W-1:0] mag_s;

  always_comb begin
    // Phase (2n+1)*k mod 32: a 5-bit product wraps naturally.
    m   = PHASE_W'({n_i, 1'b1}) * PHASE_W'(k_i);
    idx = '0;
    neg = 1'b0;
    // Fold the full circle onto the quarter-wave table.
    if (m <= PHASE_W'(8)) begin
      idx = m[3:0];
    end else if (m <= PHASE_W'(16)) begin
      idx = 4'(PHASE_W'(16) - m);
      neg = 1'b1;
    end else if (m <= PHASE_W'(24)) begin
      idx = 4'(m - PHASE_W'(16));
      neg = 1'b1;
    end else begin
      // 32 - m, computed as 0 - m in 5-bit arithmetic.
      idx = 4'(PHASE_W'(0) - m);
    end
    if (k_i == '0) begin
      mag = C0_MAG;
      neg = 1'b0;
    end else begin
      mag = TAB[idx];
    end
    mag_s  = $signed({{(COEF_W-TAB_W){1'b0}}, mag});
    coef_o = neg ? -mag_s : mag_s;
  end

endmodule

// File: rtl/dct8_mac.sv
// Serial 8-point 1-D forward DCT: loads 8 samples, emits 8 coefficients via one MAC.
// Latency: 9 cycles from the 8th input (or each output) handshake to the next out_valid.
// Backpressure: in_ready only in LOAD; out_data/out_last held stable until out_ready.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_data sample stream;
//        out_valid/out_ready/out_data/out_last coefficient stream, out_last on y[7].
module dct8_mac
  import fdct_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_last
);

  localparam int PROD_W = prod_width(DATA_W, COEF_W);
  localparam int MACC_W = acc_width(DATA_W, COEF_W);
  // Comparison width wide enough for both the accumulator and the clamp limits.
  localparam int EXT_W  = ((MACC_W > ACC_W) ? MACC_W : ACC_W) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_POINTS - 1);

  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  state_e                     state_q;
  logic [CNT_W-1:0]           n_q;
  logic [CNT_W-1:0]           k_q;
  logic signed [MACC_W-1:0]   acc_q;
  logic signed [DATA_W-1:0]   samp_q [N_POINTS];
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic                       out_last_q;
  logic signed [ACC_W-1:0]    out_data_q;

  logic signed [COEF_W-1:0]   coef;
  logic signed [DATA_W-1:0]   x_cur;
  logic signed [PROD_W-1:0]   x_ext;
  logic signed [PROD_W-1:0]   c_ext;
  logic signed [PROD_W-1:0]   prod;
  logic signed [MACC_W-1:0]   acc_d;
  logic signed [EXT_W-1:0]    acc_ext;
  logic signed [ACC_W-1:0]    sat_d;

  dct8_coef_rom #(
    .COEF_W (COEF_W)
  ) u_coef_rom (
    .k_i    (k_q),
    .n_i    (n_q),
    .coef_o (coef)
  );

  // Full-width signed product and accumulate for the current (k, n).
  assign x_cur   = samp_q[n_q];
  assign x_ext   = {{COEF_W{x_cur[DATA_W-1]}}, x_cur};
  assign c_ext   = {{DATA_W{coef[COEF_W-1]}}, coef};
  assign prod    = x_ext * c_ext;
  assign acc_d   = acc_q + {{(MACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_ext = {{(EXT_W-MACC_W){acc_d[MACC_W-1]}}, acc_d};

  always_comb begin
    if (acc_ext > SAT_MAX) begin
      sat_d = SAT_MAX[ACC_W-1:0];
    end else if (acc_ext < SAT_MIN) begin
      sat_d = SAT_MIN[ACC_W-1:0];
    end else begin
      sat_d = acc_ext[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      n_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < N_POINTS; i++) begin
        samp_q[i] <= '0;
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid && in_ready_q) begin
            samp_q[n_q] <= in_data;
            if (n_q == LAST) begin
              n_q        <= '0;
              k_q        <= '0;
              acc_q      <= '0;
              in_ready_q <= 1'b0;
              state_q    <= MAC;
            end else begin
              n_q <= n_q + 1'b1;
            end
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (n_q == LAST) begin
            n_q         <= '0;
            out_data_q  <= sat_d;
            out_valid_q <= 1'b1;
            out_last_q  <= (k_q == LAST);
            state_q     <= OUT;
          end else begin
            n_q <= n_q + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (k_q == LAST) begin
              in_ready_q <= 1'b1;
              state_q    <= LOAD;
            end else begin
              k_q     <= k_q + 1'b1;
              n_q     <= '0;
              acc_q   <= '0;
              state_q <= MAC;
            end
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_dct8_mac.sv
// Self-checking bench for dct8_mac: directed blocks, random blocks with stalls,
// and a mid-block asynchronous reset, checked against a behavioural DCT model.
module tb_dct8_mac;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int ACC_W  = 16;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_last;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int tabr [9] = '{32, 31, 30, 27, 23, 18, 12, 6, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dct8_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d (time %0t)", tag, got, exp, $time);
    end
  endtask

  // Reference cosine: C[k][n] = 32*cos((2n+1)k*pi/16) from the quarter-wave table.
  function automatic int cosv(input int k, input int n);
    int m;
    if (k == 0) return 23;
    m = ((2 * n + 1) * k) % 32;
    if (m <= 8)  return tabr[m];
    if (m <= 16) return -tabr[16 - m];
    if (m <= 24) return -tabr[m - 16];
    return tabr[32 - m];
  endfunction

  task automatic ref_block(input int xs[8], output int ys[8]);
    int s;
    for (int k = 0; k < 8; k++) begin
      s = 0;
      for (int n = 0; n < 8; n++) s += xs[n] * cosv(k, n);
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      ys[k] = s;
    end
  endtask

  // Sends 8 samples with random idle gaps; t_last is the cycle of the 8th handshake.
  task automatic send_block(input int xs[8], input int gap_max, output int t_last);
    int gap;
    int guard;
    t_last = cyc;
    for (int n = 0; n < 8; n++) begin
      gap = $urandom_range(0, gap_max);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = DATA_W'(xs[n]);
      guard = 0;
      while (!in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        check("in_ready_wait", int'(in_ready), 1);
        in_valid = 1'b0;
        return;
      end
      t_last = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Receives ncoef outputs with random stalls, checking data, last, hold and latency.
  task automatic recv_block(input int ys[8], input int t_hs, input int stall_max,
                            input int ncoef, input string tag);
    int t;
    int guard;
    int stall;
    t = t_hs;
    for (int k = 0; k < ncoef; k++) begin
      guard = 0;
      while (!out_valid && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      check($sformatf("%s_latency_k%0d", tag, k), cyc - t, 9);
      check($sformatf("%s_in_ready_busy_k%0d", tag, k), int'(in_ready), 0);
      stall = $urandom_range(0, stall_max);
      out_ready = 1'b0;
      repeat (stall) begin
        check($sformatf("%s_hold_valid_k%0d", tag, k), int'(out_valid), 1);
        check($sformatf("%s_hold_data_k%0d", tag, k), int'(out_data), ys[k]);
        @(negedge clk);
      end
      out_ready = 1'b1;
      check($sformatf("%s_valid_k%0d", tag, k), int'(out_valid), 1);
      check($sformatf("%s_data_k%0d", tag, k), int'(out_data), ys[k]);
      check($sformatf("%s_last_k%0d", tag, k), int'(out_last), (k == 7) ? 1 : 0);
      t = cyc;
      @(negedge clk);
      out_ready = 1'b0;
    end
    if (ncoef == 8) begin
      check($sformatf("%s_in_ready_return", tag), int'(in_ready), 1);
      check($sformatf("%s_valid_drop", tag), int'(out_valid), 0);
    end
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int xs [8];
    int ys [8];
    int t;
    logic signed [DATA_W-1:0] r;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_data", int'(out_data), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_out_valid", int'(out_valid), 0);

    // All-zero block.
    xs = '{default: 0};
    ys = '{default: 0};
    send_block(xs, 0, t);
    recv_block(ys, t, 2, 8, "zero");

    // Constant 10: only the DC term survives.
    xs = '{default: 10};
    ys = '{1840, 0, 0, 0, 0, 0, 0, 0};
    send_block(xs, 1, t);
    recv_block(ys, t, 2, 8, "dc10");

    // Impulse at n = 0 reads out column 0 of the cosine matrix.
    xs = '{100, 0, 0, 0, 0, 0, 0, 0};
    ys = '{2300, 3100, 3000, 2700, 2300, 1800, 1200, 600};
    send_block(xs, 0, t);
    recv_block(ys, t, 3, 8, "impulse");

    // Most negative constant: largest magnitude, must not wrap or clamp.
    xs = '{default: -128};
    ys = '{-23552, 0, 0, 0, 0, 0, 0, 0};
    send_block(xs, 0, t);
    recv_block(ys, t, 1, 8, "neg128");

    // Random blocks with input gaps and output backpressure.
    for (int b = 0; b < 100; b++) begin
      for (int n = 0; n < 8; n++) begin
        r = DATA_W'($urandom);
        xs[n] = int'(r);
      end
      ref_block(xs, ys);
      send_block(xs, 3, t);
      recv_block(ys, t, 4, 8, "rnd");
    end

    // Abort mid-block: reset while computing y[3], then a fresh impulse block.
    xs = '{100, 0, 0, 0, 0, 0, 0, 0};
    ys = '{2300, 3100, 3000, 2700, 2300, 1800, 1200, 600};
    send_block(xs, 0, t);
    recv_block(ys, t, 1, 3, "pre_abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_last", int'(out_last), 0);
    check("abort_out_data", int'(out_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_rel_in_ready", int'(in_ready), 1);
    xs = '{0, 0, 0, 0, 0, 0, 0, 0};
    xs[0] = 100;
    send_block(xs, 1, t);
    recv_block(ys, t, 2, 8, "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dct8_mac.md
# dct8_mac

Serial 8-point 1-D forward DCT engine for the fdct datapath. It accepts a row or column of eight signed samples over a valid/ready stream and computes the eight coefficients one at a time with a single multiply-accumulate unit. Each coefficient is emitted as a signed ACC_W-bit word that goes directly into the downstream `truncate` stage (WIDTH_IN = ACC_W).

## Interface
- DATA_W, 8: signed input sample width.
- COEF_W, 8: signed cosine coefficient width (scale 32 = 1.0).
- ACC_W, 16: signed output width; must be ≥ 16 for the default widths.
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  sample x[n], presented in order n = 0..7.
- out_valid  out  1  out_data holds coefficient y[k].
- out_ready  in  1  downstream accepts out_data.
- out_data  out  ACC_W  coefficient y[k], in order k = 0..7.
- out_last  out  1  high with out_valid when k = 7.

## Operation
- FSM has three states: LOAD, MAC, OUT. Reset state is LOAD.
- **Reset values:** in_ready = 1, out_valid = 0, out_last = 0, out_data = 0. The sample buffer, n, k and acc are all 0.
- **LOAD:**
  - in_ready = 1.
  - Each in_valid & in_ready handshake writes x[n] and increments n.
  - On the 8th handshake: n ← 0, k ← 0, acc ← 0, go to MAC.
- **MAC:**
  - in_ready = 0. Runs exactly 8 cycles.
  - Each cycle: acc ← acc + x[n]·C[k][n], then n++.
  - On the n = 7 cycle: out_data ← sat(acc + x[7]·C[k][7]), go to OUT.
- **OUT:**
  - out_valid = 1; out_last = (k == 7).
  - out_data and out_last hold stable until out_ready.
  - On the handshake, if k = 7: go to LOAD. Otherwise: k++, n ← 0, acc ← 0, go to MAC.
- **Coefficients:**
  - C[0][n] = 23 for all n.
  - For k > 0, C[k][n] = T[((2n+1)·k) mod 32].
  - T[m] = tab[m] for m = 0..8; −tab[16−m] for m = 8..16; −tab[m−16] for m = 16..24; tab[32−m] for m = 24..31.
  - tab[0..8] = 32, 31, 30, 27, 23, 18, 12, 6, 0.
- **Arithmetic:**
  - Products are full-width signed, DATA_W+COEF_W bits.
  - The accumulator is DATA_W+COEF_W+3 bits and never wraps.
  - sat() clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. With the defaults, saturation is unreachable (max |y| = 23552).
- Samples arriving while the block is not in LOAD are not accepted; the sender holds them.
- An asynchronous reset in any state aborts the block: the partial buffer and accumulator are discarded and all outputs return to their reset values.

## Timing
- Input throughput: one sample per cycle in LOAD.
- If the 8th sample is accepted in cycle t, out_valid for y[0] is first high in cycle t+9.
- If y[k] is accepted in cycle u, out_valid for y[k+1] is first high in cycle u+9.
- If y[7] is accepted in cycle u, in_ready is high in cycle u+1.
- Minimum period is 80 cycles per block of 8 samples.
- out_valid never drops without a handshake. out_data does not change while out_valid & !out_ready.
- in_ready depends only on registered state, never combinationally on out_ready.

## Structure
- Shared package `fdct_pkg`:
  - the tab[] constant array,
  - the state enum {LOAD, MAC, OUT},
  - N_POINTS = 8,
  - localparam helpers for the accumulator width.
- Sub-module `dct8_coef_rom`: combinational (k, n) → C[k][n], implementing the T[m] folding. Verified standalone against a table computed from tab[].
- Top level holds the FSM, the 8×DATA_W sample buffer, the n/k counters, the MAC, and the saturating output register.

## Test plan
- All-zero block → y[0..7] = 0 with out_last on y[7]; in_ready returns one cycle after the y[7] handshake.
- x[n] = 10 for all n → y[0] = 1840, y[1..7] = 0.
- Impulse x[0] = 100, others 0 → y = 2300, 3100, 3000, 2700, 2300, 1800, 1200, 600.
- x[n] = −128 for all n → y[0] = −23552 and the rest 0. Confirm no saturation or wrap.
- Random out_ready backpressure and in_valid gaps across 100 random blocks → outputs match the reference model, out_data is stable while stalled, and the latency is exactly 9 cycles after each handshake.
- Assert rst_n mid-MAC on k = 3, then release and send a fresh impulse block → outputs drop to reset values immediately, and the new block produces correct results with no residue from the aborted block.
